// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int LATENCY_DEF = 4;   // memory access cycles per transaction
    localparam int WORD_DEF    = 16;  // address / data width
    localparam int CNT_W       = 4;   // latency counter width (LATENCY <= 15)

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Down-counter that times the ACCESS phase: load on grant, count down
// while the memory access runs, flag zero on the last access cycle.
module mem_lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single fixed-latency
// memory. One transaction at a time: IDLE -> ACCESS (LATENCY cycles) -> RESP.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention
// instead of fixed data-port priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int WORD    = WORD_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [WORD-1:0] i_addr,
    output logic            i_ack,
    output logic [WORD-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [WORD-1:0] d_addr,
    input  logic [WORD-1:0] d_wdata,
    output logic            d_ack,
    output logic [WORD-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata,
    output logic            busy,
    output logic            grant_d
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_t r_state;
    logic   w_any_req;
    logic   w_grant_d;
    logic   w_load;
    logic   w_zero;

    assign w_any_req = i_req | d_req;
    assign w_load    = (r_state == IDLE) && w_any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_d;

    // On contention, hand the grant to whichever port did not win last time.
    always_comb begin
        w_grant_d = d_req && (!i_req || !r_last_d);
    end

    // Remember the most recent winner; resets to the instruction port.
    always_ff @(posedge clk) begin
        if (reset)
            r_last_d <= 1'b0;
        else if (w_load)
            r_last_d <= w_grant_d;
    end
`else
    assign w_grant_d = d_req;
`endif

    mem_lat_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (LOAD_VAL),
        .i_dec      (r_state == ACCESS),
        .o_zero     (w_zero)
    );

    // Arbitration FSM; every output is registered so the memory bus stays
    // stable for the whole ACCESS phase and acks are clean one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            grant_d   <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state   <= ACCESS;
                        busy      <= 1'b1;
                        mem_req   <= 1'b1;
                        grant_d   <= w_grant_d;
                        // Instruction fetches never write.
                        mem_we    <= w_grant_d & d_we;
                        mem_addr  <= w_grant_d ? d_addr : i_addr;
                        mem_wdata <= w_grant_d ? d_wdata : '0;
                    end
                end
                ACCESS: begin
                    if (w_zero) begin
                        r_state <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (grant_d) begin
                            d_ack   <= 1'b1;
                            // Stores return zero rather than stale bus data.
                            d_rdata <= mem_we ? '0 : mem_rdata;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 4, memory access cycles per transaction; legal range 1..15.
REQ-002 Parameter WORD, default 16, address and data width.
REQ-003 Clock and reset SHALL be one clock and a synchronous, active-high reset:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
REQ-004 Port list:
- i_req  in  1  instruction fetch request
- i_addr  in  WORD  fetch address
- i_ack  out  1  fetch complete, one-cycle pulse
- i_rdata  out  WORD  fetched word, valid with i_ack
- d_req  in  1  data request
- d_we  in  1  1=write, 0=read
- d_addr  in  WORD  data address
- d_wdata  in  WORD  store data
- d_ack  out  1  data complete, one-cycle pulse
- d_rdata  out  WORD  load data, valid with d_ack
- mem_req  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  WORD  memory address
- mem_wdata  out  WORD  memory write data
- mem_rdata  in  WORD  memory read data, valid in last ACCESS cycle
- busy  out  1  state != IDLE
- grant_d  out  1  current/last owner is data port

Function
REQ-005 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-006 IDLE: if any request is high at the clock edge, grant one requester, latch addr/we/wdata, load counter with LATENCY-1, and go to ACCESS; otherwise stay in IDLE.
REQ-007 Fixed priority (default): d_req wins over i_req when both are high.
REQ-008 ACCESS: mem_req=1 and mem_addr/mem_we/mem_wdata SHALL be driven from the latched values, held stable; counter decrements each cycle.
REQ-009 At counter==0 in ACCESS: capture mem_rdata into the owner's rdata register and go to RESP.
REQ-010 RESP: assert the owner's ack for exactly one cycle, then return to IDLE; requests are not sampled in RESP.
REQ-011 Timing: ack SHALL be high in cycle LATENCY+1 after the granting edge; back-to-back throughput is one transaction per LATENCY+2 cycles.
REQ-012 i_we does not exist; instruction transactions SHALL always drive mem_we=0.
REQ-013 Data write: d_rdata SHALL be 0 at d_ack.
REQ-014 Requests SHALL be held high until ack; the requester drops req in the cycle after ack.
REQ-015 A req dropped mid-transaction SHALL NOT abort it; the ack still pulses.
REQ-016 rdata registers SHALL hold their value until the next completion of the same port.
REQ-017 Non-owner ack SHALL stay 0 throughout a transaction.

Reset
REQ-018 Reset SHALL force IDLE, counter=0, all acks/mem_req/mem_we/busy/grant_d=0, rdata/mem_addr/mem_wdata=0, and last_grant=instruction.
REQ-019 Reset during ACCESS or RESP SHALL abandon the transaction with no ack; mem_req=0 in the first cycle after reset.

Configuration
REQ-020 With MEM_ARB_ROUND_ROBIN_EN defined: when both requests are high in IDLE, grant the port not granted last (last_grant register); a single request is granted regardless.
REQ-021 Without MEM_ARB_ROUND_ROBIN_EN: fixed data priority per REQ-007, and no last_grant register is built.

Structure
REQ-022 Package mem_arb_pkg SHALL hold the FSM state enum, the default LATENCY, WORD, and the counter width (4).
REQ-023 Sub-module mem_lat_counter (load, decrement, zero flag) SHALL implement the latency counter; arbitration and FSM stay in mem_arbiter.

Verification (LATENCY=4)
REQ-024 i_req=1, i_addr=0x0010, mem returns 0x1234 -> mem_req high for 4 cycles, i_ack in cycle 5, i_rdata=0x1234.
REQ-025 d_req=1, d_we=1, d_addr=0x0020, d_wdata=0xBEEF -> mem_we=1, mem_addr=0x0020, mem_wdata=0xBEEF for 4 cycles, d_ack in cycle 5, d_rdata=0.
REQ-026 i_req and d_req both high continuously:
- fixed mode: D, I, D grant order when each port drops req after ack
- round-robin: D, I, D, I
REQ-027 Reset asserted in the 2nd ACCESS cycle -> next cycle busy=0, mem_req=0, no ack ever issued.
REQ-028 i_req dropped after 1 ACCESS cycle -> i_ack still pulses in cycle 5; d_ack stays 0.
REQ-029 LATENCY=1 -> ACCESS lasts 1 cycle, ack in cycle 2, back-to-back period 3 cycles.
